// File: rtl/pipeline_controller.sv
// Pipeline hazard/flush control plus a fixed-latency data-memory wait sequencer.
// Latency: hazard/flush outputs are combinational; a memory access freezes exactly WAIT_CYCLES cycles, then pulses mem_ready.
module pipeline_controller #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        fwd_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  output logic        freeze_if,
  output logic        flush_if,
  output logic        flush_id,
  output logic        freeze_all,
  output logic        mem_ready,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic [15:0] stall_q, flush_q;

  logic match_exe, match_mem, hazard;
  logic frz_all, frz_if, fl_if, fl_id, rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    frz_all    = 1'b0;
    rdy        = 1'b0;
    case (state)
      RUN: begin
        if (mem_req) begin
          frz_all    = 1'b1;
          next_cnt   = CNT_LOAD;
          next_state = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        frz_all  = 1'b1;
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = MEM_DONE;
        end
      end
      MEM_DONE: begin
        // mem_req is ignored here so back-to-back accesses restart from RUN
        rdy        = 1'b1;
        next_state = RUN;
      end
      default: begin
        next_state = RUN;
        next_cnt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    match_exe = (src1 == exe_dest) || (two_src && (src2 == exe_dest));
    match_mem = (src1 == mem_dest) || (two_src && (src2 == mem_dest));
    if (fwd_en) begin
      // With forwarding only a load result in EXE is not yet available
      hazard = exe_mem_r_en && match_exe;
    end else begin
      hazard = (exe_wb_en && match_exe) || (mem_wb_en && match_mem);
    end
  end

  always_comb begin
    frz_if = 1'b1;
    fl_if  = 1'b0;
    fl_id  = 1'b0;
    if (!frz_all) begin
      frz_if = hazard && !branch_taken;
      fl_if  = branch_taken;
      fl_id  = hazard || branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if ((frz_if || frz_all) && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if ((fl_if || fl_id) && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  always_comb begin
    freeze_if   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    freeze_all  = 1'b0;
    mem_ready   = 1'b0;
    stall_count = 16'd0;
    flush_count = 16'd0;
    if (!rst) begin
      freeze_if   = frz_if;
      flush_if    = fl_if;
      flush_id    = fl_id;
      freeze_all  = frz_all;
      mem_ready   = rdy;
      stall_count = stall_q;
      flush_count = flush_q;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: vector table for hazard/flush logic plus memory-wait, reset and saturation sequences.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src1 = '0, src2 = '0, exe_dest = '0, mem_dest = '0;
  logic        two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0, mem_wb_en = 0;
  logic        fwd_en = 0, branch_taken = 0, mem_req = 0;
  logic        freeze_if, flush_if, flush_id, freeze_all, mem_ready;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  pipeline_controller #(.WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze_if(freeze_if), .flush_if(flush_if), .flush_id(flush_id),
    .freeze_all(freeze_all), .mem_ready(mem_ready),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1, s2, ed, md;
    logic       two, ewb, emr, mwb, fwd, br;
    logic       e_fi, e_fif, e_fid;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    fwd_en = 0; branch_taken = 0; mem_req = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3;
  endtask

  initial begin
    //          s1 s2 ed md two ewb emr mwb fwd br  fi fif fid
    vecs[0]  = '{3, 0, 3, 0, 0, 1, 1, 0, 1, 0,  1, 0, 1};  // load-use
    vecs[1]  = '{3, 0, 3, 0, 0, 1, 0, 0, 1, 0,  0, 0, 0};  // forwarded ALU result
    vecs[2]  = '{0, 5, 9, 5, 1, 0, 0, 1, 0, 0,  1, 0, 1};  // src2 vs MEM, no fwd
    vecs[3]  = '{0, 5, 9, 5, 0, 0, 0, 1, 0, 0,  0, 0, 0};  // src2 not valid
    vecs[4]  = '{3, 0, 3, 0, 0, 1, 1, 0, 1, 1,  0, 1, 1};  // branch beats hazard
    vecs[5]  = '{1, 2, 7, 8, 1, 1, 0, 1, 0, 1,  0, 1, 1};  // branch only
    vecs[6]  = '{6, 0, 6, 0, 0, 1, 0, 0, 0, 0,  1, 0, 1};  // src1 vs EXE, no fwd
    vecs[7]  = '{6, 0, 6, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};  // EXE not writing
    vecs[8]  = '{4, 0, 9, 4, 0, 0, 0, 1, 1, 0,  0, 0, 0};  // MEM match forwarded
    vecs[9]  = '{1, 7, 7, 0, 1, 1, 1, 0, 1, 0,  1, 0, 1};  // load-use on src2
    vecs[10] = '{1, 7, 7, 0, 0, 1, 1, 0, 1, 0,  0, 0, 0};  // src2 ignored
    vecs[11] = '{2, 2, 9, 2, 1, 0, 0, 0, 0, 0,  0, 0, 0};  // MEM not writing

    // Reset held two cycles with mem_req asserted
    clear_inputs();
    mem_req = 1;
    @(negedge clk); #1;
    check("rst_freeze_all", 16'(freeze_all), 16'd0);
    check("rst_freeze_if", 16'(freeze_if), 16'd0);
    check("rst_mem_ready", 16'(mem_ready), 16'd0);
    @(negedge clk); #1;
    check("rst_stall_count", stall_count, 16'd0);
    check("rst_flush_count", flush_count, 16'd0);
    check("rst_flush_id", 16'(flush_id), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_run_freeze_all", 16'(freeze_all), 16'd1);

    // Memory wait: 4 frozen cycles then a single ready cycle
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("memwait_freeze_%0d", i), 16'(freeze_all), 16'd1);
      check($sformatf("memwait_noready_%0d", i), 16'(mem_ready), 16'd0);
    end
    @(negedge clk); #1;
    check("memdone_ready", 16'(mem_ready), 16'd1);
    check("memdone_freeze_all", 16'(freeze_all), 16'd0);
    check("memdone_stall_count", stall_count, 16'd4);
    @(negedge clk); #1;
    check("next_access_ready", 16'(mem_ready), 16'd0);
    check("next_access_freeze", 16'(freeze_all), 16'd1);

    // Combinational hazard/flush vectors in RUN
    clear_inputs();
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      src1 = vecs[i].s1; src2 = vecs[i].s2; exe_dest = vecs[i].ed; mem_dest = vecs[i].md;
      two_src = vecs[i].two; exe_wb_en = vecs[i].ewb; exe_mem_r_en = vecs[i].emr;
      mem_wb_en = vecs[i].mwb; fwd_en = vecs[i].fwd; branch_taken = vecs[i].br;
      #1;
      check($sformatf("vec%0d_freeze_if", i), 16'(freeze_if), 16'(vecs[i].e_fi));
      check($sformatf("vec%0d_flush_if", i), 16'(flush_if), 16'(vecs[i].e_fif));
      check($sformatf("vec%0d_flush_id", i), 16'(flush_id), 16'(vecs[i].e_fid));
      check($sformatf("vec%0d_freeze_all", i), 16'(freeze_all), 16'd0);
    end

    // Branch with simultaneous access: freeze wins, branch honoured in MEM_DONE
    clear_inputs();
    do_reset(1);
    set_load_use();
    branch_taken = 1; mem_req = 1;
    #1;
    check("br_mreq_freeze_if", 16'(freeze_if), 16'd1);
    check("br_mreq_flush_if", 16'(flush_if), 16'd0);
    check("br_mreq_flush_id", 16'(flush_id), 16'd0);
    @(negedge clk);
    mem_req = 0;
    #1;
    check("br_wait_freeze_if", 16'(freeze_if), 16'd1);
    check("br_wait_flush_if", 16'(flush_if), 16'd0);
    check("br_wait_flush_id", 16'(flush_id), 16'd0);
    repeat (3) @(negedge clk);
    #1;
    check("br_done_ready", 16'(mem_ready), 16'd1);
    check("br_done_flush_if", 16'(flush_if), 16'd1);
    check("br_done_flush_id", 16'(flush_id), 16'd1);
    check("br_done_freeze_if", 16'(freeze_if), 16'd0);
    check("br_done_flush_count", flush_count, 16'd0);
    @(negedge clk); #1;
    check("br_after_flush_count", flush_count, 16'd1);
    check("br_after_stall_count", stall_count, 16'd4);

    // Reset during MEM_WAIT aborts the access
    clear_inputs();
    do_reset(1);
    mem_req = 1;
    @(negedge clk);
    mem_req = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("abort_ready_%0d", i), 16'(mem_ready), 16'd0);
      check($sformatf("abort_freeze_%0d", i), 16'(freeze_all), 16'd0);
      @(negedge clk);
    end

    // Counter saturation under a permanent hazard
    clear_inputs();
    fwd_en = 0; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3;
    do_reset(1);
    repeat (10) @(negedge clk);
    #1;
    check("sat_stall_10", stall_count, 16'd10);
    check("sat_flush_10", flush_count, 16'd10);
    repeat (69990) @(negedge clk);
    #1;
    check("sat_stall_max", stall_count, 16'hFFFF);
    check("sat_flush_max", flush_count, 16'hFFFF);
    repeat (3) @(negedge clk);
    #1;
    check("sat_stall_hold", stall_count, 16'hFFFF);
    check("sat_flush_hold", flush_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
